// File: rtl/game_timer.sv
// Countdown timer for the GAME state of the click game.
// Counts whole seconds from START_SEC down to 0 using a prescaler on pclk. It
// presents the remaining time in binary and as two BCD digits for on-screen
// rendering. It also provides a "done" level and a one-cycle "expired" strobe
// for the game FSM.
// Optional feature: define GAME_TIMER_PAUSE_EN to let the pause level freeze
// the countdown. Without the macro, pause is ignored.

module game_timer #(
    parameter int unsigned CLK_FREQ  = 40000000,
    parameter int unsigned START_SEC = 60
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    output logic [6:0] sec_left,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       expired
);

    localparam int unsigned PW         = $clog2(CLK_FREQ);
    localparam logic [6:0]  START_BIN  = 7'(START_SEC);
    localparam logic [3:0]  START_TENS = 4'(START_SEC / 10);
    localparam logic [3:0]  START_ONES = 4'(START_SEC % 10);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    sec_q, sec_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          expired_q, expired_d;
    logic          paused;
    logic          tick;

`ifdef GAME_TIMER_PAUSE_EN
    assign paused = pause;
`else
    // Port kept so the instantiation does not change; its value is ignored.
    logic unused_pause;
    assign unused_pause = pause;
    assign paused       = 1'b0;
`endif

    // The terminal count is compared at full 32-bit width so that CLK_FREQ-1 is never truncated.
    assign tick = (32'(presc_q) == (CLK_FREQ - 32'd1));

    // Next-state logic. Priority is stop > start > tick; rst is applied in the register block.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        sec_d     = sec_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        expired_d = 1'b0;

        if (stop) begin
            state_d = StIdle;
            presc_d = '0;
            sec_d   = START_BIN;
            tens_d  = START_TENS;
            ones_d  = START_ONES;
        end else if (start) begin
            state_d = StRun;
            presc_d = '0;
            sec_d   = START_BIN;
            tens_d  = START_TENS;
            ones_d  = START_ONES;
        end else begin
            case (state_q)
                StRun: begin
                    if (!paused) begin
                        if (tick) begin
                            presc_d = '0;
                            // A value of <= 1 also guards against any underflow below zero.
                            if (sec_q <= 7'd1) begin
                                sec_d     = 7'd0;
                                tens_d    = 4'd0;
                                ones_d    = 4'd0;
                                state_d   = StDone;
                                expired_d = 1'b1;
                            end else begin
                                sec_d = sec_q - 7'd1;
                                if (ones_q == 4'd0) begin
                                    ones_d = 4'd9;
                                    tens_d = tens_q - 4'd1;
                                end else begin
                                    ones_d = ones_q - 4'd1;
                                end
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State register with synchronous reset to the idle, fully loaded state.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            sec_q     <= START_BIN;
            tens_q    <= START_TENS;
            ones_q    <= START_ONES;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            sec_q     <= sec_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            expired_q <= expired_d;
        end
    end

    // All outputs are taken from registered state, so no input reaches an output combinationally.
    always_comb begin
        sec_left = sec_q;
        sec_tens = tens_q;
        sec_ones = ones_q;
        running  = (state_q == StRun);
        done     = (state_q == StDone);
        expired  = expired_q;
    end

endmodule

// File: tb/tb_game_timer.sv
// Directed testbench for game_timer, with hand-computed expected values.
// One instance uses CLK_FREQ=4 and START_SEC=3, and a second uses START_SEC=10 to cover the BCD behaviour.

module tb_game_timer;

    logic       pclk;
    logic       rst;
    logic       start, stop, pause;
    logic [6:0] sec_left;
    logic [3:0] sec_tens, sec_ones;
    logic       running, done, expired;

    logic       start10, stop10;
    logic [6:0] sec10;
    logic [3:0] tens10, ones10;
    logic       run10, done10, exp10;

    int n_vec;
    int n_fail;
    int exp_k;

    game_timer #(
        .CLK_FREQ (4),
        .START_SEC(3)
    ) u_dut (
        .pclk    (pclk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .sec_left(sec_left),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .running (running),
        .done    (done),
        .expired (expired)
    );

    game_timer #(
        .CLK_FREQ (4),
        .START_SEC(10)
    ) u_dut10 (
        .pclk    (pclk),
        .rst     (rst),
        .start   (start10),
        .stop    (stop10),
        .pause   (1'b0),
        .sec_left(sec10),
        .sec_tens(tens10),
        .sec_ones(ones10),
        .running (run10),
        .done    (done10),
        .expired (exp10)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Watchdog: the run must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Wait for the next active edge, then settle; outputs now show the result of that edge.
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic expect_main(input string tag, input int sec, input int run, input int dn,
                               input int ex);
        check_eq({tag, ".sec"}, int'(sec_left), sec);
        check_eq({tag, ".tens"}, int'(sec_tens), sec / 10);
        check_eq({tag, ".ones"}, int'(sec_ones), sec % 10);
        check_eq({tag, ".running"}, int'(running), run);
        check_eq({tag, ".done"}, int'(done), dn);
        check_eq({tag, ".expired"}, int'(expired), ex);
    endtask

    initial begin
        n_vec   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        pause   = 1'b0;
        start10 = 1'b0;
        stop10  = 1'b0;

        // Reset, then 20 idle cycles.
        step();
        step();
        expect_main("reset", 3, 0, 0, 0);
        check_eq("reset10.sec", int'(sec10), 10);
        check_eq("reset10.tens", int'(tens10), 1);
        check_eq("reset10.ones", int'(ones10), 0);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            expect_main("idle", 3, 0, 0, 0);
        end

        // Full countdown: the start edge is E, and ticks fall at E+4, E+8 and E+12.
        start = 1'b1;
        step();
        start = 1'b0;
        expect_main("cd.E", 3, 1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            expect_main("cd", 3 - k / 4, (k < 12) ? 1 : 0, (k == 12) ? 1 : 0, (k == 12) ? 1 : 0);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            expect_main("cd.hold", 0, 0, 1, 0);
        end

        // Stop from DONE returns the timer to idle.
        stop = 1'b1;
        step();
        stop = 1'b0;
        expect_main("done.stop", 3, 0, 0, 0);

        // Abort 1: stop at E+6.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            expect_main("ab1.run", (k < 4) ? 3 : 2, 1, 0, 0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        expect_main("ab1.stop", 3, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            expect_main("ab1.idle", 3, 0, 0, 0);
        end

        // Abort 2: start and stop together at E+2; stop wins.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        expect_main("ab2", 3, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            expect_main("ab2.idle", 3, 0, 0, 0);
        end

        // Abort 3: stop on the same edge as the final tick.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step();
            expect_main("ab3.run", 3 - k / 4, 1, 0, 0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        expect_main("ab3.stop", 3, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            expect_main("ab3.idle", 3, 0, 0, 0);
        end

        // Pause: pause is held high for the edges E+5 through E+9.
`ifdef GAME_TIMER_PAUSE_EN
        exp_k = 17;
`else
        exp_k = 12;
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        pause = 1'b1;
        for (int k = 5; k <= 9; k++) begin
            step();
            check_eq("pause.running", int'(running), 1);
            check_eq("pause.expired", int'(expired), 0);
        end
        pause = 1'b0;
        for (int k = 10; k <= 20; k++) begin
            step();
            check_eq("pause.expired", int'(expired), (k == exp_k) ? 1 : 0);
            check_eq("pause.done", int'(done), (k >= exp_k) ? 1 : 0);
            check_eq("pause.running", int'(running), (k < exp_k) ? 1 : 0);
        end
        check_eq("pause.sec_end", int'(sec_left), 0);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // Mid-run reset at E+7.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_main("rst.mid", 3, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            expect_main("rst.idle", 3, 0, 0, 0);
        end

        // BCD check with START_SEC=10; a restart on the 5th tick (E+20) reloads the count.
        start10 = 1'b1;
        step();
        start10 = 1'b0;
        check_eq("bcd.E.tens", int'(tens10), 1);
        check_eq("bcd.E.ones", int'(ones10), 0);
        check_eq("bcd.E.run", int'(run10), 1);
        for (int k = 1; k <= 24; k++) begin
            int es;
            start10 = (k == 20);
            step();
            start10 = 1'b0;
            if (k < 20) es = 10 - k / 4;
            else if (k < 24) es = 10;
            else es = 9;
            check_eq("bcd.sec", int'(sec10), es);
            check_eq("bcd.tens", int'(tens10), es / 10);
            check_eq("bcd.ones", int'(ones10), es % 10);
            check_eq("bcd.sum", int'(tens10) * 10 + int'(ones10), int'(sec10));
            check_eq("bcd.expired", int'(exp10), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
